// File: rtl/shadowmask_loader.sv
// shadowmask_loader: fetches a mask image (header + LUT rows) from a
// 1-cycle-latency pattern memory and replays it to the shadow-mask block
// as a tear-free command stream: disable, vmax, hmax, LUT words, enable.
// Optional feature macro: SHADOWMASK_LOADER_VBLANK_SYNC_EN holds the load
// in WAIT_VB until a rising edge of vs_in.
module shadowmask_loader (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  mask_sel,
  input  logic [2:0]  mode,
  input  logic        vs_in,
  output logic [11:0] mem_addr,
  input  logic [15:0] mem_rdata,
  output logic        cmd_wr,
  output logic [15:0] cmd_in,
  output logic        busy,
  output logic        done
);

  // Each state is named after the command word present on cmd_in in it.
  typedef enum logic [3:0] {
    S_IDLE,
`ifdef SHADOWMASK_LOADER_VBLANK_SYNC_EN
    S_WAIT_VB,
`endif
    S_HDR,
    S_CTRL0,
    S_VMAX,
    S_HMAX,
    S_LUT,
    S_CTRL1,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic [8:0]  off_q, off_d;     // word offset inside the slot, 0..256
  logic [8:0]  cnt_q, cnt_d;     // LUT words issued; 9 bits so 256 fits
  logic        cmd_wr_q, cmd_wr_d;
  logic [15:0] cmd_in_q, cmd_in_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [2:0]  mode_q, mode_d;
  logic [3:0]  vmax_q, vmax_d;
  logic [3:0]  hmax_q, hmax_d;

  logic [4:0]  rows;
  logic [8:0]  n_entries;
  logic [8:0]  off_inc;
  logic [15:0] lut_word;
  logic        vs_rise;

`ifdef SHADOWMASK_LOADER_VBLANK_SYNC_EN
  logic vs_prev_q;
  assign vs_rise = vs_in & ~vs_prev_q;
`else
  assign vs_rise = 1'b0;
`endif

  // Whole 16-entry rows keep the consumer's auto-increment index on {v,h}.
  assign rows      = {1'b0, vmax_q} + 5'd1;
  assign n_entries = {rows, 4'b0000};
  // Address stops at base+N so nothing past the image is ever read.
  assign off_inc   = (off_q < n_entries) ? off_q + 9'd1 : off_q;
  assign lut_word  = {3'b011, 2'b00, mem_rdata[10:0]};

  logic unused_ok;
  assign unused_ok = &{1'b0, mem_rdata[15:11], vs_rise, vs_in};

  // Next-state and registered-output computation.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    off_d    = off_q;
    cnt_d    = cnt_q;
    cmd_wr_d = 1'b0;
    cmd_in_d = cmd_in_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    mode_d   = mode_q;
    vmax_d   = vmax_q;
    hmax_d   = hmax_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sel_d  = mask_sel;
          mode_d = mode;
          off_d  = 9'd0;
          cnt_d  = 9'd0;
          busy_d = 1'b1;
`ifdef SHADOWMASK_LOADER_VBLANK_SYNC_EN
          state_d = S_WAIT_VB;
`else
          state_d = S_HDR;
`endif
        end
      end
`ifdef SHADOWMASK_LOADER_VBLANK_SYNC_EN
      S_WAIT_VB: begin
        if (vs_rise) state_d = S_HDR;
      end
`endif
      S_HDR: begin
        cmd_wr_d = 1'b1;
        cmd_in_d = 16'h0000;
        state_d  = S_CTRL0;
      end
      S_CTRL0: begin
        vmax_d   = mem_rdata[7:4];
        hmax_d   = mem_rdata[3:0];
        cmd_wr_d = 1'b1;
        cmd_in_d = {3'b001, 9'b0, mem_rdata[7:4]};
        off_d    = off_inc;
        state_d  = S_VMAX;
      end
      S_VMAX: begin
        cmd_wr_d = 1'b1;
        cmd_in_d = {3'b010, 9'b0, hmax_q};
        off_d    = off_inc;
        state_d  = S_HMAX;
      end
      S_HMAX: begin
        cmd_wr_d = 1'b1;
        cmd_in_d = lut_word;
        cnt_d    = 9'd1;
        off_d    = off_inc;
        state_d  = S_LUT;
      end
      S_LUT: begin
        cmd_wr_d = 1'b1;
        off_d    = off_inc;
        if (cnt_q == n_entries) begin
          cmd_in_d = {3'b000, 9'b0, mode_q, 1'b0};
          state_d  = S_CTRL1;
        end else begin
          cmd_in_d = lut_word;
          cnt_d    = cnt_q + 9'd1;
        end
      end
      S_CTRL1: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      sel_q    <= 3'd0;
      off_q    <= 9'd0;
      cnt_q    <= 9'd0;
      cmd_wr_q <= 1'b0;
      cmd_in_q <= 16'h0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      off_q    <= off_d;
      cnt_q    <= cnt_d;
      cmd_wr_q <= cmd_wr_d;
      cmd_in_q <= cmd_in_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Captured mode and header fields; only read after being loaded.
  always_ff @(posedge clk_sys) begin
    mode_q <= mode_d;
    vmax_q <= vmax_d;
    hmax_q <= hmax_d;
  end

`ifdef SHADOWMASK_LOADER_VBLANK_SYNC_EN
  // Previous vs_in, tracked in every state so an edge is never missed.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) vs_prev_q <= 1'b0;
    else          vs_prev_q <= vs_in;
  end
`endif

  assign mem_addr = {sel_q, off_q};
  assign cmd_wr   = cmd_wr_q;
  assign cmd_in   = cmd_in_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
